// File: rtl/ripple_mon_pkg.sv
// Shared types and constants for the ripple counter monitor.
package ripple_mon_pkg;
    localparam int CNT_W       = 4;
    localparam int WRAP_W_DEF  = 8;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        INIT,
        TRACK,
        FAULT
    } mon_state_e;
endpackage

// File: rtl/ripple_count_monitor_sync_2ff.sv
// Two-flop synchroniser for a bus; bits may resolve on different cycles, so the
// consumer must qualify the output itself.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] s1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/ripple_count_monitor.sv
// Tracks a free-running asynchronous 4-bit ripple counter and extends it with a wrap count.
// Optional skip detection (sticky err + FAULT state) is enabled by RIPPLE_MON_SKIP_DET_EN.
module ripple_count_monitor
    import ripple_mon_pkg::*;
#(
    parameter int WRAP_W = WRAP_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CNT_W-1:0]        q_in,
    input  logic                    err_clr,
    output logic [CNT_W-1:0]        count_q,
    output logic [WRAP_W+CNT_W-1:0] ext_count,
    output logic                    step,
    output logic                    wrap,
    output logic                    err
);
    logic [CNT_W-1:0]     s2, s3;
    logic [SYNC_STAGES:0] vld_pipe;
    logic [WRAP_W-1:0]    wrap_cnt, wrap_cnt_n;
    logic [CNT_W-1:0]     count_n, count_inc;
    logic                 step_n, wrap_n;
    logic                 stable, skip;
    mon_state_e           state, state_n;

    sync_2ff #(.W(CNT_W)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (q_in),
        .q     (s2)
    );

    // s2 == s3 is only meaningful once both hold genuinely sampled data, so the
    // flushed zeros left behind by reset are never taken as a first count.
    assign stable    = vld_pipe[SYNC_STAGES] && (s2 == s3);
    assign count_inc = count_q + 1'b1;
    assign skip      = stable && (s2 != count_q) && (s2 != count_inc);
    assign ext_count = {wrap_cnt, count_q};

`ifdef RIPPLE_MON_SKIP_DET_EN
    logic err_q, err_n;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        count_n    = count_q;
        wrap_cnt_n = wrap_cnt;
        step_n     = 1'b0;
        wrap_n     = 1'b0;
`ifdef RIPPLE_MON_SKIP_DET_EN
        err_n      = err_q;
`endif
        case (state)
            INIT: begin
                if (stable) begin
                    count_n = s2;
                    state_n = TRACK;
                end
            end
            TRACK: begin
                if (stable && (s2 != count_q)) begin
                    count_n = s2;
                    if (s2 == count_inc) begin
                        step_n = 1'b1;
                        if (count_q == {CNT_W{1'b1}}) begin
                            wrap_n     = 1'b1;
                            wrap_cnt_n = wrap_cnt + 1'b1;
                        end
                    end
`ifdef RIPPLE_MON_SKIP_DET_EN
                    else begin
                        err_n   = 1'b1;
                        state_n = FAULT;
                    end
`endif
                end
            end
            FAULT: begin
                if (stable) count_n = s2;
                // A fresh skip arriving with the clear request keeps the fault alive.
                if (err_clr && !skip) begin
`ifdef RIPPLE_MON_SKIP_DET_EN
                    err_n   = 1'b0;
`endif
                    state_n = INIT;
                end
            end
            default: state_n = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s3       <= '0;
            vld_pipe <= '0;
            state    <= INIT;
            count_q  <= '0;
            wrap_cnt <= '0;
            step     <= 1'b0;
            wrap     <= 1'b0;
`ifdef RIPPLE_MON_SKIP_DET_EN
            err_q    <= 1'b0;
`endif
        end else begin
            s3       <= s2;
            vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
            state    <= state_n;
            count_q  <= count_n;
            wrap_cnt <= wrap_cnt_n;
            step     <= step_n;
            wrap     <= wrap_n;
`ifdef RIPPLE_MON_SKIP_DET_EN
            err_q    <= err_n;
`endif
        end
    end
endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed + randomized bench for ripple_count_monitor against a value-level reference model.
module tb_ripple_count_monitor;
    localparam int WRAP_W = 8;
`ifdef RIPPLE_MON_SKIP_DET_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif
    localparam int M_INIT = 0, M_TRACK = 1, M_FAULT = 2;

    logic              clk = 1'b0;
    logic              reset, err_clr, step, wrap, err;
    logic [3:0]        q_in, count_q;
    logic [WRAP_W+3:0] ext_count;

    int checks = 0, errors = 0;
    int step_seen = 0, wrap_seen = 0;
    int m_cnt = 0, m_wc = 0, m_err = 0, m_mode = M_INIT, m_steps = 0, m_wraps = 0;
    int cur_q = 0;

    always #5 clk = ~clk;

    ripple_count_monitor #(.WRAP_W(WRAP_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .q_in      (q_in),
        .err_clr   (err_clr),
        .count_q   (count_q),
        .ext_count (ext_count),
        .step      (step),
        .wrap      (wrap),
        .err       (err)
    );

    // Every high cycle counts, so a pulse stretched to two cycles shows up as extra.
    always @(negedge clk) begin
        if (step === 1'b1) step_seen++;
        if (wrap === 1'b1) wrap_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: each value held long enough is accepted once, in order.
    task automatic model_apply(input int v);
        case (m_mode)
            M_INIT: begin
                m_cnt  = v;
                m_mode = M_TRACK;
            end
            M_TRACK: begin
                if (v != m_cnt) begin
                    if (v == (m_cnt + 1) % 16) begin
                        m_steps++;
                        if (m_cnt == 15) begin
                            m_wraps++;
                            m_wc = (m_wc + 1) % (1 << WRAP_W);
                        end
                    end else if (SKIP_EN) begin
                        m_err  = 1;
                        m_mode = M_FAULT;
                    end
                    m_cnt = v;
                end
            end
            default: m_cnt = v;
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, " count_q"}, 32'(count_q), m_cnt);
        check({tag, " ext_count"}, 32'(ext_count), (m_wc << 4) | m_cnt);
        check({tag, " err"}, 32'(err), m_err);
        check({tag, " steps"}, step_seen, m_steps);
        check({tag, " wraps"}, wrap_seen, m_wraps);
    endtask

    task automatic hold(input int v, input int n, input string tag);
        q_in  = 4'(v);
        cur_q = v;
        repeat (n) @(posedge clk);
        @(negedge clk); #1;
        model_apply(v);
        check_all(tag);
    endtask

    task automatic reset_dut(input int n, input string tag);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk); #1;
        m_cnt = 0; m_wc = 0; m_err = 0; m_mode = M_INIT;
        check_all(tag);
        check({tag, " step"}, 32'(step), 0);
        check({tag, " wrap"}, 32'(wrap), 0);
        reset = 1'b0;
    endtask

    task automatic clear_err(input string tag);
        err_clr = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        err_clr = 1'b0;
        @(posedge clk); @(negedge clk); #1;
        if (m_mode == M_FAULT) begin
            m_mode = M_INIT;
            m_err  = 0;
        end
        model_apply(cur_q);
        check_all(tag);
    endtask

    initial begin
        int s0, w0, v, r;
        reset   = 1'b1;
        err_clr = 1'b0;
        q_in    = 4'($urandom_range(0, 15));

        // Reset, then first value with exact latency.
        reset_dut(2, "reset");
        q_in  = 4'd5;
        cur_q = 5;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("latency_early count_q", 32'(count_q), 0);
        @(posedge clk); @(negedge clk); #1;
        model_apply(5);
        check_all("first_load");
        check("first_load no_step", step_seen, 0);

        // Full lap 0..15,0,1.
        reset_dut(1, "reset2");
        hold(0, 4, "lap_start");
        s0 = step_seen;
        w0 = wrap_seen;
        for (int i = 1; i < 16; i++) hold(i, 4, "lap");
        hold(0, 4, "lap_wrap");
        hold(1, 4, "lap_end");
        check("lap step_pulses", step_seen - s0, 17);
        check("lap wrap_pulses", wrap_seen - w0, 1);
        check("lap ext_count", 32'(ext_count), 32'h011);

        // Single-cycle glitch is filtered.
        hold(2, 4, "pre_glitch");
        hold(3, 4, "pre_glitch");
        s0 = step_seen;
        q_in = 4'd7;
        @(posedge clk); @(negedge clk); #1;
        hold(3, 5, "glitch");
        check("glitch count_q", 32'(count_q), 3);
        check("glitch step_pulses", step_seen - s0, 0);
        check("glitch err", 32'(err), 0);

        // Jump 4 -> 9.
        hold(4, 4, "pre_jump");
        s0 = step_seen;
        hold(9, 4, "jump");
        check("jump count_q", 32'(count_q), 9);
        check("jump no_step", step_seen - s0, 0);
`ifdef RIPPLE_MON_SKIP_DET_EN
        check("jump err", 32'(err), 1);
        hold(10, 4, "fault_track");
        // Skip lands on the same edge as err_clr: fault must persist.
        q_in  = 4'd3;
        cur_q = 3;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        err_clr = 1'b0;
        model_apply(3);
        check_all("clr_vs_skip");
        check("clr_vs_skip err", 32'(err), 1);
        s0 = step_seen;
        clear_err("clear");
        check("clear err", 32'(err), 0);
        check("clear silent_load", step_seen - s0, 0);
        hold(4, 4, "after_clear_step");
`else
        check("jump err", 32'(err), 0);
        hold(10, 4, "track_after_jump");
        clear_err("clr_ignored");
`endif

        // Build wrap_cnt = 3, provoke a skip, then reset mid-operation.
        reset_dut(1, "reset3");
        hold(0, 4, "laps_start");
        for (int lap = 0; lap < 3; lap++) begin
            for (int i = 1; i < 16; i++) hold(i, 4, "laps");
            hold(0, 4, "laps_wrap");
        end
        check("laps wrap_cnt", 32'(ext_count[WRAP_W+3:4]), 3);
        hold(7, 4, "pre_reset_skip");
        reset_dut(1, "reset_mid");
        s0 = step_seen;
        hold(11, 4, "post_reset_load");
        check("post_reset no_step", step_seen - s0, 0);

        // Randomized tail, biased towards legal steps.
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      v = (m_cnt + 1) % 16;
            else if (r < 8) v = m_cnt;
            else            v = $urandom_range(0, 15);
            hold(v, $urandom_range(4, 6), "rand");
            if (m_mode == M_FAULT && $urandom_range(0, 1) == 1) clear_err("rand_clear");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
